mode_sequencer: RTL and testbench
=================================

// Module: mode_sequencer
// PURPOSE
//  Upstream driver of the stimulus stage in the BER test chain. Steps {MAIN_MODE,SUB_MODE}
//  through a programmed range: settle window, then measurement window, per step.
//  MEAS_EN gates the downstream BER counters. STEP_DONE marks each step for result capture.
//  Idle output {0,0} decodes to the disabled control word downstream.
// PARAMETERS
//  DW_W        16  width of DWELL (measurement cycles per step)
//  SETTLE_CYC  4   settle cycles per step, >=2 (covers 1-cycle stimulus register + DUT settle)
// PORTS
//  CLK        in   1     single clock; all logic on posedge
//  RST        in   1     synchronous reset, active-high
//  START      in   1     1-cycle run request; sampled only in IDLE
//  ABORT      in   1     stop run; priority over all other events
//  MAIN_FIRST in   8     first MAIN_MODE of run
//  MAIN_LAST  in   8     last MAIN_MODE of run (inclusive)
//  SUB_LAST   in   8     SUB_MODE runs 0..SUB_LAST per MAIN_MODE
//  DWELL      in   DW_W  MEAS_EN cycles per step; 0 treated as 1
//  MAIN_MODE  out  8     registered mode to stimulus stage
//  SUB_MODE   out  8     registered sub-mode to stimulus stage
//  MEAS_EN    out  1     measurement window, high exactly max(DWELL,1) cycles per step
//  STEP_DONE  out  1     1-cycle pulse after each step's last MEAS_EN cycle
//  BUSY       out  1     run in progress
//  DONE       out  1     1-cycle pulse on normal completion
//  ABORTED    out  1     1-cycle pulse on abort
//  CFG_ERR    out  1     1-cycle pulse: START with MAIN_FIRST>MAIN_LAST
// BEHAVIOUR
//  - Reset (RST=1 at edge, any state incl. mid-run): state IDLE; all outputs 0.
//  - FSM states: IDLE, SETTLE, MEASURE.
//  - IDLE + START, FIRST<=LAST:
//      latch MAIN_LAST, SUB_LAST, DWELL (later input changes ignored);
//      MAIN_MODE<=MAIN_FIRST, SUB_MODE<=0, BUSY<=1; ->SETTLE, settle cnt<=SETTLE_CYC-1.
//  - IDLE + START, FIRST>LAST: CFG_ERR pulse; stay IDLE, BUSY stays 0.
//  - SETTLE: count down; cnt==0 -> MEASURE, MEAS_EN<=1, dwell cnt<=max(DWELL,1)-1.
//  - MEASURE: count down; cnt==0 -> MEAS_EN<=0, STEP_DONE<=1 (same edge), then:
//      SUB<SUB_LAST            : SUB_MODE+1; ->SETTLE
//      SUB==SUB_LAST, MAIN<LAST: MAIN_MODE+1, SUB_MODE<=0; ->SETTLE
//      both last               : MAIN/SUB<=0, BUSY<=0, DONE<=1; ->IDLE
//  - Compare before increment: MAIN_LAST=255 or SUB_LAST=255 never wraps.
//  - Step period = SETTLE_CYC+max(DWELL,1) cycles; STEP_DONE coincides with next step's first SETTLE cycle.
//  - Modes change only on step-advance edges, never while MEAS_EN=1.
//  - ABORT in SETTLE/MEASURE: next edge ->IDLE; modes 0, MEAS_EN 0, BUSY 0, ABORTED 1;
//    no STEP_DONE/DONE, even if same cycle as last dwell cycle.
//  - ABORT in IDLE: no effect. START while BUSY: ignored.
//  - Simultaneous START+ABORT in IDLE: START is accepted.
// TESTING
//  1. MAIN 9..9, SUB_LAST=3, DWELL=10, START @edge0
//       -> MEAS_EN high edges 14k+4..14k+13; STEP_DONE @14,28,42 (SUB=1,2,3);
//          DONE @56; modes 0 after.
//  2. MAIN 30..31, SUB_LAST=0, DWELL=1
//       -> sequence (30,0),(31,0); exactly 2 STEP_DONE pulses before DONE; 1-cycle MEAS_EN each.
//  3. MAIN 255..255, SUB_LAST=255, DWELL=0
//       -> 256 steps, MAIN stays 255, SUB 0..255 with no wrap; DWELL=0 gives 1-cycle MEAS_EN.
//  4. ABORT during MEASURE of step 2, incl. its last dwell cycle
//       -> ABORTED pulse, no STEP_DONE/DONE, all outputs 0 next edge.
//  5. START while BUSY; config changes mid-run
//       -> ignored, run unchanged.
//     START with FIRST=12, LAST=10
//       -> CFG_ERR pulse, BUSY stays 0.
//  6. RST=1 mid-SETTLE and mid-MEASURE
//       -> all outputs 0 next edge; fresh START runs normally.

Source files
------------

// File: rtl/mode_sequencer.sv
// mode_sequencer
//   Steps {main_mode, sub_mode} through a programmed range for the BER test
//   chain. Each step consists of a settle window (SETTLE_CYC cycles) followed
//   by a measurement window (max(dwell,1) cycles) during which meas_en is high.
//   Idle outputs are all zero, which downstream decodes as the disabled word.
//
// Parameters
//   DW_W        width of dwell
//   SETTLE_CYC  settle cycles per step (>= 2)
//
// Ports
//   clk         clock, all logic on posedge
//   rst         synchronous active-high reset
//   start       1-cycle run request, sampled only when idle
//   abort       stop run, highest priority while running
//   main_first  first main mode of the run
//   main_last   last main mode of the run (inclusive)
//   sub_last    sub mode runs 0..sub_last for each main mode
//   dwell       measurement cycles per step (0 behaves as 1)
//   main_mode   registered main mode to the stimulus stage
//   sub_mode    registered sub mode to the stimulus stage
//   meas_en     measurement window
//   step_done   1-cycle pulse after the last measurement cycle of a step
//   busy        run in progress
//   done        1-cycle pulse on normal completion
//   aborted     1-cycle pulse on abort
//   cfg_err     1-cycle pulse on start with main_first > main_last
module mode_sequencer #(
  parameter int DW_W       = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [7:0]      main_first,
  input  logic [7:0]      main_last,
  input  logic [7:0]      sub_last,
  input  logic [DW_W-1:0] dwell,
  output logic [7:0]      main_mode,
  output logic [7:0]      sub_mode,
  output logic            meas_en,
  output logic            step_done,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            cfg_err
);

  // One down-counter serves both windows, so it must hold either reload value.
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W = (DW_W > SET_W) ? DW_W : SET_W;
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]      main_reg, main_next;
  logic [7:0]      sub_reg, sub_next;
  logic [7:0]      main_last_reg, main_last_next;
  logic [7:0]      sub_last_reg, sub_last_next;
  logic [DW_W-1:0] dwell_m1_reg, dwell_m1_next;
  logic            meas_en_reg, meas_en_next;
  logic            step_done_reg, step_done_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            aborted_reg, aborted_next;
  logic            cfg_err_reg, cfg_err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      main_reg      <= '0;
      sub_reg       <= '0;
      main_last_reg <= '0;
      sub_last_reg  <= '0;
      dwell_m1_reg  <= '0;
      meas_en_reg   <= 1'b0;
      step_done_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      aborted_reg   <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      main_reg      <= main_next;
      sub_reg       <= sub_next;
      main_last_reg <= main_last_next;
      sub_last_reg  <= sub_last_next;
      dwell_m1_reg  <= dwell_m1_next;
      meas_en_reg   <= meas_en_next;
      step_done_reg <= step_done_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      aborted_reg   <= aborted_next;
      cfg_err_reg   <= cfg_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    main_next      = main_reg;
    sub_next       = sub_reg;
    main_last_next = main_last_reg;
    sub_last_next  = sub_last_reg;
    dwell_m1_next  = dwell_m1_reg;
    meas_en_next   = meas_en_reg;
    busy_next      = busy_reg;
    step_done_next = 1'b0;
    done_next      = 1'b0;
    aborted_next   = 1'b0;
    cfg_err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        // abort is deliberately ignored here so start+abort starts a run.
        if (start) begin
          if (main_first <= main_last) begin
            main_last_next = main_last;
            sub_last_next  = sub_last;
            dwell_m1_next  = (dwell == '0) ? '0 : dwell - 1'b1;
            main_next      = main_first;
            sub_next       = '0;
            busy_next      = 1'b1;
            cnt_next       = SETTLE_RELOAD;
            state_next     = SETTLE;
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end

      SETTLE: begin
        if (abort) begin
          state_next   = IDLE;
          main_next    = '0;
          sub_next     = '0;
          meas_en_next = 1'b0;
          busy_next    = 1'b0;
          aborted_next = 1'b1;
        end else if (cnt_reg == '0) begin
          state_next   = MEASURE;
          meas_en_next = 1'b1;
          cnt_next     = CNT_W'(dwell_m1_reg);
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      MEASURE: begin
        if (abort) begin
          // Abort wins even on the final dwell cycle: no step_done/done.
          state_next   = IDLE;
          main_next    = '0;
          sub_next     = '0;
          meas_en_next = 1'b0;
          busy_next    = 1'b0;
          aborted_next = 1'b1;
        end else if (cnt_reg == '0) begin
          meas_en_next   = 1'b0;
          step_done_next = 1'b1;
          // Compare against the last value before incrementing so that a
          // last value of 255 terminates instead of wrapping.
          if (sub_reg < sub_last_reg) begin
            sub_next   = sub_reg + 8'd1;
            cnt_next   = SETTLE_RELOAD;
            state_next = SETTLE;
          end else if (main_reg < main_last_reg) begin
            main_next  = main_reg + 8'd1;
            sub_next   = '0;
            cnt_next   = SETTLE_RELOAD;
            state_next = SETTLE;
          end else begin
            main_next  = '0;
            sub_next   = '0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign main_mode = main_reg;
  assign sub_mode  = sub_reg;
  assign meas_en   = meas_en_reg;
  assign step_done = step_done_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign aborted   = aborted_reg;
  assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer
//   Randomized and directed stimulus for mode_sequencer. A timeline model
//   derives every expected output from the elapsed cycles since the start
//   edge (step = elapsed / period, offset = elapsed % period); one compare
//   process checks all outputs each cycle, and directed sections pin the
//   model with hand-computed literal expectations.
module tb_mode_sequencer;
  localparam int DW_W       = 16;
  localparam int SETTLE_CYC = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic [7:0]      main_first;
  logic [7:0]      main_last;
  logic [7:0]      sub_last;
  logic [DW_W-1:0] dwell;
  logic [7:0]      main_mode;
  logic [7:0]      sub_mode;
  logic            meas_en;
  logic            step_done;
  logic            busy;
  logic            done;
  logic            aborted;
  logic            cfg_err;

  always #5 clk = ~clk;

  mode_sequencer #(.DW_W(DW_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .main_first(main_first), .main_last(main_last), .sub_last(sub_last),
    .dwell(dwell), .main_mode(main_mode), .sub_mode(sub_mode),
    .meas_en(meas_en), .step_done(step_done), .busy(busy), .done(done),
    .aborted(aborted), .cfg_err(cfg_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- timeline model ----------------
  int  cyc = 0;
  bit  run_on = 0;
  bit  model_valid = 0;
  int  run_start, m_first, m_last, s_last, dw_eff;
  int  done_edge = -1, abort_edge = -1, cfg_edge = -1;
  logic [7:0] e_main, e_sub;
  logic       e_meas, e_sd, e_busy, e_done, e_ab, e_cfg;

  always @(posedge clk) begin
    int el, per, nsteps, s, o;
    cyc = cyc + 1;
    if (rst) begin
      run_on = 0;
    end else if (run_on) begin
      el     = cyc - run_start;
      per    = SETTLE_CYC + dw_eff;
      nsteps = (m_last - m_first + 1) * (s_last + 1);
      if (abort) begin
        run_on     = 0;
        abort_edge = cyc;
      end else if (el == nsteps * per) begin
        run_on    = 0;
        done_edge = cyc;
      end
    end else if (start) begin
      if (main_first <= main_last) begin
        run_on    = 1;
        run_start = cyc;
        m_first   = int'(main_first);
        m_last    = int'(main_last);
        s_last    = int'(sub_last);
        dw_eff    = (dwell == '0) ? 1 : int'(dwell);
      end else begin
        cfg_edge = cyc;
      end
    end
    e_main = '0; e_sub = '0; e_meas = 0; e_sd = 0; e_busy = 0;
    e_done = 0; e_ab = 0; e_cfg = 0;
    if (run_on) begin
      el     = cyc - run_start;
      per    = SETTLE_CYC + dw_eff;
      s      = el / per;
      o      = el % per;
      e_main = 8'(m_first + s / (s_last + 1));
      e_sub  = 8'(s % (s_last + 1));
      e_meas = (o >= SETTLE_CYC);
      e_sd   = (o == 0) && (s > 0);
      e_busy = 1;
    end
    if (done_edge == cyc) begin
      e_done = 1;
      e_sd   = 1;
    end
    if (abort_edge == cyc) e_ab = 1;
    if (cfg_edge == cyc) e_cfg = 1;
    model_valid = 1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      n_checks++;
      if ({main_mode, sub_mode, meas_en, step_done, busy, done, aborted, cfg_err} !==
          {e_main, e_sub, e_meas, e_sd, e_busy, e_done, e_ab, e_cfg}) begin
        n_fail++;
        $display("FAIL model_cmp cyc=%0d got main=%0d sub=%0d meas=%b sd=%b busy=%b done=%b ab=%b cfg=%b exp main=%0d sub=%0d meas=%b sd=%b busy=%b done=%b ab=%b cfg=%b",
                 cyc, main_mode, sub_mode, meas_en, step_done, busy, done, aborted, cfg_err,
                 e_main, e_sub, e_meas, e_sd, e_busy, e_done, e_ab, e_cfg);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check_lit(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge following the start edge ("after edge 0").
  task automatic do_start(input int f, input int l, input int sl, input int dw);
    @(negedge clk);
    main_first = 8'(f); main_last = 8'(l); sub_last = 8'(sl); dwell = DW_W'(dw);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (busy === 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_lit("wait_idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int sd_cnt, me_cnt, dn_cnt;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    main_first = '0; main_last = '0; sub_last = '0; dwell = '0;
    tick(3);
    check_lit("reset_busy", int'(busy), 0);
    check_lit("reset_main", int'(main_mode), 0);
    rst = 1'b0;
    tick(2);

    // 1: MAIN 9..9, SUB_LAST=3, DWELL=10 (period 14)
    do_start(9, 9, 3, 10);
    check_lit("t1_main_e0", int'(main_mode), 9);
    tick(3);
    check_lit("t1_meas_e3", int'(meas_en), 0);
    tick(1);
    check_lit("t1_meas_e4", int'(meas_en), 1);
    tick(9);
    check_lit("t1_meas_e13", int'(meas_en), 1);
    tick(1);
    check_lit("t1_sd_e14", int'(step_done), 1);
    check_lit("t1_sub_e14", int'(sub_mode), 1);
    check_lit("t1_meas_e14", int'(meas_en), 0);
    tick(42);
    check_lit("t1_done_e56", int'(done), 1);
    check_lit("t1_busy_e56", int'(busy), 0);
    check_lit("t1_main_e56", int'(main_mode), 0);
    tick(2);

    // 2: MAIN 30..31, SUB_LAST=0, DWELL=1 (period 5, done at edge 10)
    do_start(30, 31, 0, 1);
    sd_cnt = 0; me_cnt = 0; dn_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      sd_cnt += int'(step_done);
      me_cnt += int'(meas_en);
      dn_cnt += int'(done);
      if (i == 5) check_lit("t2_main_e5", int'(main_mode), 31);
      @(negedge clk);
    end
    check_lit("t2_step_done_cnt", sd_cnt, 2);
    check_lit("t2_meas_cnt", me_cnt, 2);
    check_lit("t2_done_cnt", dn_cnt, 1);

    // 3: 255..255, SUB_LAST=255, DWELL=0 (period 5, 256 steps)
    do_start(255, 255, 255, 0);
    tick(1275);
    check_lit("t3_sub_last", int'(sub_mode), 255);
    check_lit("t3_main_last", int'(main_mode), 255);
    tick(4);
    check_lit("t3_meas_last", int'(meas_en), 1);
    tick(1);
    check_lit("t3_done", int'(done), 1);
    check_lit("t3_sub_zero", int'(sub_mode), 0);
    tick(2);

    // 4: abort on last dwell cycle of step 2 (period 7, edge 14)
    do_start(5, 6, 1, 3);
    tick(13);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_lit("t4_aborted", int'(aborted), 1);
    check_lit("t4_no_sd", int'(step_done), 0);
    check_lit("t4_no_done", int'(done), 0);
    check_lit("t4_main_zero", int'(main_mode), 0);
    tick(1);
    check_lit("t4_aborted_1cyc", int'(aborted), 0);
    // abort mid-measure
    do_start(5, 6, 1, 3);
    tick(11);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_lit("t4b_aborted", int'(aborted), 1);
    check_lit("t4b_meas", int'(meas_en), 0);
    tick(2);

    // 5: start while busy + config changes (2*3 steps, period 6, done edge 36)
    do_start(1, 2, 2, 2);
    tick(3);
    start = 1'b1; main_last = 8'd0; sub_last = 8'd7; dwell = 16'd9;
    tick(1);
    start = 1'b0;
    tick(31);
    check_lit("t5_busy_e35", int'(busy), 1);
    tick(1);
    check_lit("t5_done_e36", int'(done), 1);
    tick(1);
    @(negedge clk);
    main_first = 8'd12; main_last = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_lit("t5_cfg_err", int'(cfg_err), 1);
    check_lit("t5_cfg_busy", int'(busy), 0);
    tick(1);
    check_lit("t5_cfg_err_1cyc", int'(cfg_err), 0);
    // start + abort together in idle: start wins
    @(negedge clk);
    main_first = 8'd3; main_last = 8'd3; sub_last = 8'd0; dwell = 16'd2;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_lit("t5_start_abort", int'(busy), 1);
    wait_idle(50);

    // 6: reset mid-settle and mid-measure
    do_start(7, 8, 1, 4);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_lit("t6_rst_settle_busy", int'(busy), 0);
    check_lit("t6_rst_settle_main", int'(main_mode), 0);
    do_start(7, 8, 1, 4);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_lit("t6_rst_meas", int'(meas_en), 0);
    do_start(7, 7, 1, 2);
    wait_idle(100);

    // randomized runs
    for (int it = 0; it < 60; it++) begin
      int f;
      f = int'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0)
        do_start(f, (f == 0) ? 0 : f - 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      else
        do_start(f, (f + int'($urandom_range(0, 2)) > 255) ? 255 : f + int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      for (int c = 0; c < 400; c++) begin
        if (busy !== 1'b1) break;
        start = ($urandom_range(0, 19) == 0);
        abort = ($urandom_range(0, 149) == 0);
        rst   = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 9) == 0) begin
          main_first = 8'($urandom); main_last = 8'($urandom);
          sub_last = 8'($urandom); dwell = DW_W'($urandom);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst = 1'b0;
      end
      check_lit("rand_run_bounded", int'(busy), 0);
      tick(int'($urandom_range(0, 3)));
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
